// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one registered memory port between requester 0 (CPU) and requester 1.
// Build option MEM_ARB_RR_EN selects round-robin tie breaking; default is fixed m0 priority.
module mem_arbiter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        m0_stb,
   input  logic [19:0] m0_addr,
   input  logic [15:0] m0_wr_data,
   input  logic        m0_we,
   input  logic        m0_byte_m,
   input  logic        m0_lock,
   output logic        m0_ack,
   output logic [15:0] m0_rd_data,
   input  logic        m1_stb,
   input  logic [19:0] m1_addr,
   input  logic [15:0] m1_wr_data,
   input  logic        m1_we,
   input  logic        m1_byte_m,
   output logic        m1_ack,
   output logic [15:0] m1_rd_data,
   output logic [19:0] mem_addr,
   output logic [15:0] mem_wr_data,
   output logic        mem_we,
   output logic        mem_byte_m,
   input  logic [15:0] mem_rd_data
);

   typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, ACK = 2'd2} state_t;

   typedef struct packed {
      logic [19:0] addr;
      logic [15:0] wr_data;
      logic        we;
      logic        byte_m;
   } mem_req_t;

   state_t   state, state_nxt;
   logic     gnt;
   logic     lock_hold;
   logic     lock_q;
   logic     elig0, elig1;
   logic     grant, win;
   mem_req_t req0, req1, win_req;

`ifdef MEM_ARB_RR_EN
   logic     last_gnt;
`endif

   assign req0 = '{addr: m0_addr, wr_data: m0_wr_data, we: m0_we, byte_m: m0_byte_m};
   assign req1 = '{addr: m1_addr, wr_data: m1_wr_data, we: m1_we, byte_m: m1_byte_m};

   // A held lock shuts m1 out completely, even while m0 is idle.
   assign elig0 = m0_stb;
   assign elig1 = m1_stb & ~lock_hold;

   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      win       = 1'b0;
      case (state)
         IDLE: begin
            if (elig0 | elig1) begin
               grant     = 1'b1;
               state_nxt = ACC;
               if (elig0 & elig1) begin
`ifdef MEM_ARB_RR_EN
                  win = ~last_gnt;
`else
                  win = 1'b0;
`endif
               end else begin
                  win = elig1;
               end
            end
         end
         ACC:     state_nxt = ACK;
         ACK:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign win_req = win ? req1 : req0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Memory port is fully registered; rd_data is captured at the edge that ends ACC,
   // which is also the write edge, so a write returns the pre-write contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt         <= 1'b0;
         lock_hold   <= 1'b0;
         lock_q      <= 1'b0;
         m0_ack      <= 1'b0;
         m1_ack      <= 1'b0;
         m0_rd_data  <= 16'h0000;
         m1_rd_data  <= 16'h0000;
         mem_addr    <= 20'h00000;
         mem_wr_data <= 16'h0000;
         mem_we      <= 1'b0;
         mem_byte_m  <= 1'b0;
      end else begin
         m0_ack <= 1'b0;
         m1_ack <= 1'b0;
         if (grant) begin
            gnt         <= win;
            lock_q      <= ~win & m0_lock;
            mem_addr    <= win_req.addr;
            mem_wr_data <= win_req.wr_data;
            mem_we      <= win_req.we;
            mem_byte_m  <= win_req.byte_m;
         end
         if (state == ACC) begin
            mem_we <= 1'b0;
            if (gnt) begin
               m1_rd_data <= mem_rd_data;
               m1_ack     <= 1'b1;
            end else begin
               m0_rd_data <= mem_rd_data;
               m0_ack     <= 1'b1;
               lock_hold  <= lock_q;
            end
         end
      end
   end

`ifdef MEM_ARB_RR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     last_gnt <= 1'b1;
      else if (grant) last_gnt <= win;
   end
`endif

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single simulation memory port (20-bit byte address, 16-bit data, byte/word mode, synchronous write, combinational read) between the CPU (requester 0) and a secondary bus master such as DMA or video (requester 1). It latches one request at a time, drives the memory port from registers for exactly one access cycle, and returns read data with a one-cycle acknowledge. Requester 0 can lock the port across consecutive transactions for atomic read-modify-write sequences.

## Interface
- No parameters. Widths are fixed to the memory port: address 20, data 16.
- clk  in  1  sole clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- m0_stb, m1_stb  in  1  request strobe; held high with fields stable until the matching ack
- m0_addr, m1_addr  in  20  byte address
- m0_wr_data, m1_wr_data  in  16  write data; bits [7:0] only in byte mode
- m0_we, m1_we  in  1  1 = write, 0 = read
- m0_byte_m, m1_byte_m  in  1  1 = byte access, 0 = word access
- m0_lock  in  1  sampled with m0's request; 1 = keep the port reserved for m0 after this transaction
- m0_ack, m1_ack  out  1  one-cycle completion pulse
- m0_rd_data, m1_rd_data  out  16  registered read data, valid while ack is high and held until the next ack on that port
- mem_addr  out  20  memory address, registered
- mem_wr_data  out  16  memory write data, registered
- mem_we  out  1  memory write enable, registered; high only in ACC
- mem_byte_m  out  1  memory byte mode, registered
- mem_rd_data  in  16  memory read data; combinational from mem_addr and mem_byte_m

## Operation
- FSM: IDLE → ACC → ACK → IDLE. The FSM handles one transaction at a time.
- **IDLE:** evaluate the strobes.
  - If a grant is made, latch the winner's addr, wr_data, we and byte_m into mem_*, record the winner in `gnt`, and go to ACC.
  - If no strobe is eligible, stay in IDLE with mem_we = 0.
- **ACC:** mem_* hold stable for one cycle.
  - At the ending edge, the memory performs the write if mem_we = 1.
  - The arbiter captures mem_rd_data into the granted port's rd_data register; this happens on writes too (value = pre-write memory contents).
  - mem_we clears at this edge. Go to ACK.
- **ACK:** the granted port's ack is 1 for this cycle only. Go to IDLE. A strobe still high in the following IDLE cycle is a new request.
- Arbitration (see Configuration):
  - Only one requester: it wins.
  - Both requesting: priority decides.
- Lock:
  - `lock_hold` is set at the ACC-ending edge of an m0 transaction with m0_lock = 1.
  - It is cleared at the ACC-ending edge of an m0 transaction with m0_lock = 0.
  - While lock_hold = 1, m1 is never granted, and the FSM idles if m0_stb = 0.
- Read data is passed through unmodified; byte-mode sign extension is done by the memory.
- The non-granted port's rd_data and ack are unaffected by a transaction.

## Timing
- Request sampled high in IDLE at edge E0:
  - mem_* are valid in the cycle after E0 (ACC).
  - ack is high in the second cycle after E0.
  - Throughput is one transaction per 3 cycles.
- Reset (async, rst_n = 0):
  - state = IDLE, gnt = 0, last_gnt = 1, lock_hold = 0
  - all acks = 0, both rd_data = 0, mem_addr = 0, mem_wr_data = 0, mem_we = 0, mem_byte_m = 0
- Reset asserted during ACC: mem_we drops immediately, so no write occurs. The transaction is dropped with no ack, and the requester must reissue it.
- A strobe dropped before ack (protocol violation): the transaction still completes and acks.
- Address wrap: a word access at 20'hFFFFF is passed through unchanged; the memory wraps the upper byte to 20'h00000.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration.
  - If both requesters strobe in IDLE, grant the one not in `last_gnt`.
  - `last_gnt` updates on every grant.
  - The reset value last_gnt = 1 makes m0 win the first tie.
- `MEM_ARB_RR_EN` undefined: fixed priority; m0 always wins ties and m1 can starve. `last_gnt` is not implemented.
- Lock behaviour is identical in both builds.

## Test plan
- Single word write then read on m0: write 16'hBEEF to 20'h00100 with byte_m = 0; then read 20'h00100.
  - Each ack arrives exactly 2 cycles after the strobe is sampled.
  - The read returns 16'hBEEF.
- Byte read with sign extension on m1: the byte at 20'h00200 is 8'h85; read with byte_m = 1.
  - m1_rd_data = 16'hFF85, and m0_rd_data is unchanged.
- Simultaneous strobes, both held for 4 transactions:
  - With `MEM_ARB_RR_EN`: grant order m0, m1, m0, m1.
  - Without it: all 4 grants go to m0 while m1 stays pending.
- Lock: m0 reads with m0_lock = 1 while m1_stb is high; m0 idles 2 cycles, then writes with m0_lock = 0.
  - m1 is not granted until after m0's write acks.
  - The memory shows m0's write value before m1 accesses it.
- Reset during ACC of a write of 16'h1234 to 20'h00300 (old value 16'h0000):
  - mem_we = 0 immediately and no ack is issued.
  - The memory still holds 16'h0000.
  - After release, all outputs are at their reset values and the next request completes normally.
- Wrap: word write of 16'hA55A at 20'hFFFFF.
  - The byte at 20'hFFFFF is 8'h5A and the byte at 20'h00000 is 8'hA5.
